// File: rtl/disp_sched_if.sv
// Requester handshake bundle for disp_sched: two valid/ready ports carrying
// a four-hex-digit display value each.
interface disp_sched_if;
   logic        req0_valid;
   logic [15:0] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [15:0] req1_data;
   logic        req1_ready;

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data,
      input  req0_ready, req1_ready
   );

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data,
      output req0_ready, req1_ready
   );
endinterface

// File: rtl/disp_sched.sv
// Two-requester display scheduler with minimum dwell per grant and round-robin ties.
// Optional leading-zero blanking is enabled by defining DISP_SCHED_LZB_EN.
module disp_sched #(
   parameter int DWELL_CYC = 100000000,
   parameter int CNT_W     = 27
) (
   input  logic          clk,
   input  logic          reset,
   disp_sched_if.slave   bus,
   output logic [3:0]    A,
   output logic [3:0]    B,
   output logic [3:0]    C,
   output logic [3:0]    D,
   output logic [3:0]    blank,
   output logic [1:0]    owner
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OWN0 = 2'd1;
   localparam logic [1:0] ST_OWN1 = 2'd2;
   localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DWELL_CYC - 1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_last;
   logic [15:0]      r_disp;
   logic [3:0]       r_blank;
   logic [1:0]       r_owner;

   logic w_expired;
   logic w_grant0;
   logic w_grant1;
   logic w_rdy0;
   logic w_rdy1;
   logic w_ready0;
   logic w_ready1;
   logic w_xfer0;
   logic w_xfer1;

   function automatic logic [3:0] f_blank(input logic [15:0] d);
      logic [3:0] b;
`ifdef DISP_SCHED_LZB_EN
      b[3] = (d[15:12] == 4'h0);
      b[2] = (d[15:8]  == 8'h00);
      b[1] = (d[15:4]  == 12'h000);
      b[0] = 1'b0;
`else
      b = 4'b0000;
`endif
      return b;
   endfunction

   assign w_expired = (r_cnt == LP_CNT_MAX);

   // Grant and ready decision; a waiting port may only pre-empt an expired owner.
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      w_rdy0   = 1'b0;
      w_rdy1   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.req0_valid && bus.req1_valid) begin
               if (r_last) begin
                  w_grant0 = 1'b1;
               end else begin
                  w_grant1 = 1'b1;
               end
            end else if (bus.req0_valid) begin
               w_grant0 = 1'b1;
            end else if (bus.req1_valid) begin
               w_grant1 = 1'b1;
            end else begin
               w_grant0 = 1'b0;
            end
            w_rdy0 = w_grant0;
            w_rdy1 = w_grant1;
         end
         ST_OWN0: begin
            if (w_expired && bus.req1_valid) begin
               w_grant1 = 1'b1;
               w_rdy1   = 1'b1;
            end else begin
               w_rdy0 = bus.req0_valid;
            end
         end
         ST_OWN1: begin
            if (w_expired && bus.req0_valid) begin
               w_grant0 = 1'b1;
               w_rdy0   = 1'b1;
            end else begin
               w_rdy1 = bus.req1_valid;
            end
         end
         default: begin
            w_rdy0 = 1'b0;
         end
      endcase
   end

   assign w_ready0       = w_rdy0 & ~reset;
   assign w_ready1       = w_rdy1 & ~reset;
   assign w_xfer0        = w_ready0 & bus.req0_valid;
   assign w_xfer1        = w_ready1 & bus.req1_valid;
   assign bus.req0_ready = w_ready0;
   assign bus.req1_ready = w_ready1;

   // Ownership state, dwell counter and last-served tracking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_last  <= 1'b1;
      end else if (w_grant0) begin
         r_state <= ST_OWN0;
         r_cnt   <= '0;
         r_last  <= 1'b0;
      end else if (w_grant1) begin
         r_state <= ST_OWN1;
         r_cnt   <= '0;
         r_last  <= 1'b1;
      end else if ((r_state != ST_IDLE) && !w_expired) begin
         r_cnt   <= r_cnt + CNT_W'(1);
      end else begin
         r_cnt   <= r_cnt;
      end
   end

   // Display value, blanking and owner register together on every transfer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_disp  <= 16'h0000;
         r_blank <= 4'b1111;
         r_owner <= 2'b00;
      end else if (w_xfer0) begin
         r_disp  <= bus.req0_data;
         r_blank <= f_blank(bus.req0_data);
         r_owner <= 2'b01;
      end else if (w_xfer1) begin
         r_disp  <= bus.req1_data;
         r_blank <= f_blank(bus.req1_data);
         r_owner <= 2'b10;
      end else begin
         r_disp  <= r_disp;
         r_blank <= r_blank;
         r_owner <= r_owner;
      end
   end

   assign A     = r_disp[15:12];
   assign B     = r_disp[11:8];
   assign C     = r_disp[7:4];
   assign D     = r_disp[3:0];
   assign blank = r_blank;
   assign owner = r_owner;

endmodule

// File: doc/disp_sched.md
DISP_SCHED -- requirements
Module: disp_sched

Interface
REQ-001 SHALL have parameter DWELL_CYC, default 100000000; minimum clock cycles a granted requester owns the display (1 s at 100 MHz); legal range 2..2^27-1.
REQ-002 SHALL have parameter CNT_W, default 27; width of the dwell counter.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0_valid, req1_valid  input  1 each  requester n presents a display value.
REQ-006 SHALL have ports req0_data, req1_data  input  16 each  four hex digits, [15:12] leftmost.
REQ-007 SHALL have ports req0_ready, req1_ready  output  1 each  combinational; transfer occurs on a rising edge where valid and ready are both high.
REQ-008 SHALL have ports A, B, C, D  output  4 each  registered digit values, A leftmost, for the four-digit display multiplexer.
REQ-009 SHALL have port blank  output  4  registered per-digit blank, bit 3 = A, 1 = blank.
REQ-010 SHALL have port owner  output  2  registered; 00 none, 01 port 0, 10 port 1.

Function
REQ-011 SHALL implement states IDLE, OWN0 and OWN1; IDLE is entered only from reset.
REQ-012 In IDLE, a single valid requester SHALL be granted; if both are valid, the requester not served last SHALL be granted (last-served register resets to port 1, so port 0 wins the first tie).
REQ-013 A grant SHALL: assert that port's ready in the same cycle; latch its data; move to OWNn; clear the dwell counter to 0.
REQ-014 In OWNn before dwell expiry, readyn SHALL equal validn; each transfer SHALL update the displayed value and SHALL NOT restart the dwell counter; the other port's ready SHALL be 0.
REQ-015 Dwell counter SHALL increment each cycle in OWNn and saturate at DWELL_CYC-1 (dwell expired); it SHALL never wrap.
REQ-016 After expiry, if the other port is valid, it SHALL be granted per REQ-013 in that cycle, and the current owner's ready SHALL be 0 in that cycle even if it is valid.
REQ-017 After expiry with the other port not valid, the owner SHALL remain granted and keep accepting per REQ-014.
REQ-018 A, B, C and D SHALL update on the clock edge after a transfer; latency is 1 cycle.
REQ-019 owner SHALL update on the clock edge after a transfer.
REQ-020 Without a transfer, the display SHALL hold its last value indefinitely.
REQ-021 In IDLE, blank SHALL be 4'b1111.
REQ-022 In OWNn, blank SHALL be per REQ-030/REQ-031.
REQ-023 Both ready outputs SHALL be 0 while reset is asserted.

Reset
REQ-024 Assertion of reset SHALL immediately force state IDLE, owner 00, A=B=C=D=0, blank 4'b1111, dwell counter 0, and last-served port 1.
REQ-025 Reset asserted mid-dwell SHALL discard the ownership and the latched data; the first grant after release SHALL follow REQ-012.
REQ-026 Leaving IDLE SHALL require one rising edge with reset low.

Configuration
REQ-027 Macro DISP_SCHED_LZB_EN SHALL select leading-zero blanking.
REQ-028 With DISP_SCHED_LZB_EN defined, blank[3] SHALL be set when digit A = 0.
REQ-029 With DISP_SCHED_LZB_EN defined, blank[2] SHALL be set when A and B = 0, and blank[1] when A, B and C = 0; blank[0] SHALL always be 0.
REQ-030 With DISP_SCHED_LZB_EN undefined, blank SHALL be 4'b0000 in OWNn.
REQ-031 In both configurations, blank SHALL be registered alongside the digits in the same cycle.

Verification (DWELL_CYC=8)
REQ-032 Reset release, then req0 valid with 16'h0042 -> req0_ready high that cycle; next cycle owner=01, A..D=0,0,4,2; blank=4'b1100 (LZB) / 4'b0000 (no LZB).
REQ-033 From IDLE, both valid in the same cycle -> port 0 granted and req1_ready low; second tie after a fresh reset is also granted to port 0.
REQ-034 OWN0, req1 valid at cycle 2 of dwell -> req1 stalled until the counter reaches 7, then granted that cycle with req0_ready low; owner=10 next cycle.
REQ-035 OWN0 expired, req1 idle; req0 sends 16'h1234 -> accepted, owner stays 01, blank=4'b0000.
REQ-036 Reset asserted mid-dwell with display 16'hBEEF -> outputs immediately 0 and blank 4'b1111, both readies low, owner=00.
